// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Imported by pc_sequencer and its redirect latch.
package pc_sequencer_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_redirect_latch.sv
// Holds trap/branch/halt requests that arrive while a fetch is stalled.
// The newest branch target overwrites any older latched one.
module redirect_latch
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = PC_W
) (
    input  logic             cl,
    input  logic             clear,
    input  logic             capture,
    input  logic             flush,
    input  logic             trap,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt,
    output logic             trap_p,
    output logic             branch_p,
    output logic             halt_p,
    output logic [WIDTH-1:0] target_p
);

    always_ff @(posedge cl or negedge clear) begin
        if (!clear) begin
            trap_p   <= 1'b0;
            branch_p <= 1'b0;
            halt_p   <= 1'b0;
            target_p <= '0;
        end else if (flush) begin
            trap_p   <= 1'b0;
            branch_p <= 1'b0;
            halt_p   <= 1'b0;
        end else if (capture) begin
            trap_p   <= trap_p | trap;
            branch_p <= branch_p | branch_valid;
            halt_p   <= halt_p | halt;
            if (branch_valid) begin
                target_p <= branch_target;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Drives the external PC counter's clear/load strobes and runs the
// instruction-fetch handshake, folding in branch, trap and halt requests.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = PC_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(TRAP_VECTOR_DEF)
) (
    input  logic             cl,
    input  logic             clear,
    input  logic [WIDTH-1:0] pc_y,
    output logic             pc_clear_n,
    output logic             pc_load_n,
    output logic [WIDTH-1:0] pc_x,
    output logic             mem_req,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] fetch_addr,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             trap,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] epc,
    output logic             halted
);

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic             flush;
    logic             epc_we;
    logic             trap_p;
    logic             branch_p;
    logic             halt_p;
    logic [WIDTH-1:0] target_p;
    logic             eff_trap;
    logic             eff_branch;
    logic             eff_halt;
    logic [WIDTH-1:0] eff_target;

    redirect_latch #(
        .WIDTH(WIDTH)
    ) u_latch (
        .cl           (cl),
        .clear        (clear),
        .capture      (capture),
        .flush        (flush),
        .trap         (trap),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halt         (halt),
        .trap_p       (trap_p),
        .branch_p     (branch_p),
        .halt_p       (halt_p),
        .target_p     (target_p)
    );

    assign fetch_addr = pc_y;
    assign eff_trap   = trap | trap_p;
    assign eff_branch = branch_valid | branch_p;
    assign eff_halt   = halt | halt_p;
    assign eff_target = branch_valid ? branch_target : target_p;

    always_ff @(posedge cl or negedge clear) begin
        if (!clear) begin
            state <= ST_INIT;
            epc   <= '0;
        end else begin
            state <= state_nxt;
            if (epc_we) begin
                epc <= pc_y;
            end
        end
    end

    // The counter increments unless loaded, so holding means reloading pc_y.
    always_comb begin
        state_nxt  = state;
        pc_clear_n = 1'b1;
        pc_load_n  = 1'b1;
        pc_x       = pc_y;
        mem_req    = 1'b0;
        halted     = 1'b0;
        capture    = 1'b0;
        flush      = 1'b0;
        epc_we     = 1'b0;
        unique case (state)
            ST_INIT: begin
                pc_load_n = 1'b0;
                pc_x      = RESET_VECTOR;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (!mem_ready) begin
                    pc_load_n = 1'b0;
                    capture   = 1'b1;
                end else begin
                    flush     = 1'b1;
                    state_nxt = eff_halt ? ST_HALT : ST_FETCH;
                    if (eff_trap) begin
                        pc_load_n = 1'b0;
                        pc_x      = TRAP_VECTOR;
                        epc_we    = 1'b1;
                    end else if (eff_branch) begin
                        pc_load_n = 1'b0;
                        pc_x      = eff_target;
                    end
                end
            end
            ST_HALT: begin
                halted    = 1'b1;
                pc_load_n = 1'b0;
                if (trap) begin
                    pc_x      = TRAP_VECTOR;
                    epc_we    = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (branch_valid) begin
                    pc_x = branch_target;
                end else if (resume) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        if (!clear) begin
            pc_clear_n = 1'b0;
            pc_load_n  = 1'b1;
            pc_x       = '0;
            mem_req    = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural PC counter beside it.
// Vector tables feed a scoreboard queue; async reset is checked by hand.
module tb_pc_sequencer;

    typedef struct {
        logic        mr;
        logic        bv;
        logic [31:0] bt;
        logic        tr;
        logic        hl;
        logic        rs;
        logic        req;
        logic        ldn;
        logic [31:0] pcx;
        logic [31:0] addr;
        logic        hlt;
        logic [31:0] epc;
    } vec_t;

    logic        cl = 1'b0;
    logic        clear;
    logic [31:0] pc_y;
    logic        pc_clear_n;
    logic        pc_load_n;
    logic [31:0] pc_x;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] fetch_addr;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        trap;
    logic        halt;
    logic        resume;
    logic [31:0] epc;
    logic        halted;

    int   n_run  = 0;
    int   n_fail = 0;
    vec_t tbl1[$];
    vec_t tbl2[$];
    vec_t sb[$];

    pc_sequencer dut (
        .cl           (cl),
        .clear        (clear),
        .pc_y         (pc_y),
        .pc_clear_n   (pc_clear_n),
        .pc_load_n    (pc_load_n),
        .pc_x         (pc_x),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .fetch_addr   (fetch_addr),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .trap         (trap),
        .halt         (halt),
        .resume       (resume),
        .epc          (epc),
        .halted       (halted)
    );

    always #5 cl = ~cl;

    // External counter: sync clear, load, otherwise +1
    always @(posedge cl) begin
        if (!pc_clear_n)
            pc_y <= 32'h0;
        else if (!pc_load_n)
            pc_y <= pc_x;
        else
            pc_y <= pc_y + 32'h1;
    end

    function automatic vec_t v(
        input logic mr, input logic bv, input logic [31:0] bt,
        input logic tr, input logic hl, input logic rs,
        input logic req, input logic ldn, input logic [31:0] pcx,
        input logic [31:0] addr, input logic hlt, input logic [31:0] e);
        vec_t r;
        r.mr = mr; r.bv = bv; r.bt = bt; r.tr = tr; r.hl = hl; r.rs = rs;
        r.req = req; r.ldn = ldn; r.pcx = pcx; r.addr = addr;
        r.hlt = hlt; r.epc = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        mem_ready     = t.mr;
        branch_valid  = t.bv;
        branch_target = t.bt;
        trap          = t.tr;
        halt          = t.hl;
        resume        = t.rs;
        sb.push_back(t);
    endtask

    task automatic check_out(input string tag, input int idx);
        vec_t e;
        logic ok;
        e  = sb.pop_front();
        ok = (mem_req === e.req) && (pc_load_n === e.ldn) &&
             (pc_clear_n === 1'b1) && (e.ldn || pc_x === e.pcx) &&
             (fetch_addr === e.addr) && (halted === e.hlt) &&
             (epc === e.epc);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s[%0d]: got req=%b ld_n=%b clr_n=%b x=%h addr=%h hlt=%b epc=%h expected req=%b ld_n=%b clr_n=1 x=%h addr=%h hlt=%b epc=%h",
                     tag, idx, mem_req, pc_load_n, pc_clear_n, pc_x,
                     fetch_addr, halted, epc, e.req, e.ldn, e.pcx,
                     e.addr, e.hlt, e.epc);
        end
    endtask

    task automatic run_tbl(input string tag, input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            drive(t[i]);
            @(negedge cl);
            check_out(tag, i);
            @(posedge cl);
            #1;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_clr_n"}, {31'h0, pc_clear_n}, 32'h0);
        chk({tag, "_ld_n"}, {31'h0, pc_load_n}, 32'h1);
        chk({tag, "_pc_x"}, pc_x, 32'h0);
        chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_epc"}, epc, 32'h0);
    endtask

    initial begin
        //           mr bv bt           tr hl rs req ld x            addr         h  epc
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 0,0,32'h0,     32'h0,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h0,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h1,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h2,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h3,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h4,       0,32'h0));
        tbl1.push_back(v(0,0,32'h0,      0,0,0, 1,0,32'h5,     32'h5,       0,32'h0));
        tbl1.push_back(v(0,0,32'h0,      0,0,0, 1,0,32'h5,     32'h5,       0,32'h0));
        tbl1.push_back(v(0,0,32'h0,      0,0,0, 1,0,32'h5,     32'h5,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h5,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h6,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h7,       0,32'h0));
        tbl1.push_back(v(0,1,32'h40,     0,0,0, 1,0,32'h8,     32'h8,       0,32'h0));
        tbl1.push_back(v(0,1,32'h80,     0,0,0, 1,0,32'h8,     32'h8,       0,32'h0));
        tbl1.push_back(v(0,0,32'h0,      0,0,0, 1,0,32'h8,     32'h8,       0,32'h0));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,0,32'h80,    32'h8,       0,32'h0));
        tbl1.push_back(v(1,1,32'h10,     0,0,0, 1,0,32'h10,    32'h80,      0,32'h0));
        tbl1.push_back(v(1,1,32'h200,    1,0,0, 1,0,32'h100,   32'h10,      0,32'h0));
        tbl1.push_back(v(1,1,32'h20,     0,0,0, 1,0,32'h20,    32'h100,     0,32'h10));
        tbl1.push_back(v(1,0,32'h0,      0,1,0, 1,1,32'h0,     32'h20,      0,32'h10));
        for (int k = 0; k < 5; k++)
            tbl1.push_back(v(1,0,32'h0,  0,0,0, 0,0,32'h21,    32'h21,      1,32'h10));
        tbl1.push_back(v(1,0,32'h0,      0,1,1, 0,0,32'h21,    32'h21,      1,32'h10));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h21,      0,32'h10));
        tbl1.push_back(v(0,0,32'h0,      0,1,0, 1,0,32'h22,    32'h22,      0,32'h10));
        tbl1.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h22,      0,32'h10));
        tbl1.push_back(v(1,1,32'h30,     0,0,0, 0,0,32'h30,    32'h23,      1,32'h10));
        tbl1.push_back(v(1,0,32'h0,      1,0,0, 0,0,32'h100,   32'h30,      1,32'h10));
        tbl1.push_back(v(0,0,32'h0,      0,0,0, 1,0,32'h100,   32'h100,     0,32'h30));

        tbl2.push_back(v(1,0,32'h0,      0,0,0, 0,0,32'h0,     32'h0,       0,32'h0));
        tbl2.push_back(v(1,1,32'hFFFF_FFFF,0,0,0,1,0,32'hFFFF_FFFF,32'h0,   0,32'h0));
        tbl2.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'hFFFF_FFFF,0,32'h0));
        tbl2.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h0,       0,32'h0));
        tbl2.push_back(v(0,0,32'h0,      1,0,0, 1,0,32'h1,     32'h1,       0,32'h0));
        tbl2.push_back(v(0,0,32'h0,      0,0,1, 1,0,32'h1,     32'h1,       0,32'h0));
        tbl2.push_back(v(1,0,32'h0,      0,0,0, 1,0,32'h100,   32'h1,       0,32'h0));
        tbl2.push_back(v(1,0,32'h0,      0,0,0, 1,1,32'h0,     32'h100,     0,32'h1));

        clear         = 1'b0;
        mem_ready     = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        trap          = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
        pc_y          = 32'hDEAD_BEEF;
        repeat (3) @(negedge cl);
        reset_checks("rst0");

        @(posedge cl);
        #1 clear = 1'b1;
        run_tbl("seq", tbl1);

        // Mid-stall async reset: request must drop without a clock edge
        mem_ready = 1'b0;
        #2;
        chk("stall_req", {31'h0, mem_req}, 32'h1);
        clear = 1'b0;
        #1;
        reset_checks("async");
        repeat (2) @(negedge cl);
        chk("rst_counter", pc_y, 32'h0);

        @(posedge cl);
        #1 clear = 1'b1;
        run_tbl("wrap", tbl2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
